// File: rtl/sub_pkg.sv
// Shared widths and the stage-1 pipeline record for the two-stage 8-bit subtractor.
package sub_pkg;

  localparam int WIDTH = 8;
  localparam int NIB   = 4;

  // c3 holds the carry out of the low nibble, which becomes the carry-in of the high nibble
  typedef struct packed {
    logic [NIB-1:0] d_lo;
    logic           c3;
    logic [NIB-1:0] a_hi;
    logic [NIB-1:0] nb_hi;
  } s1_t;

endpackage

// File: rtl/sub_cla_4.sv
// 4-bit carry-lookahead adder slice; c3 is the carry into bit 3, used for signed overflow.
module sub_cla_4
  import sub_pkg::*;
(
  input  logic [NIB-1:0] x,
  input  logic [NIB-1:0] y,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout,
  output logic           c3
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // All carries are flattened into two-level lookahead terms instead of rippling
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[NIB-1:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/sub_8_pipe.sv
// Two-stage pipelined 8-bit subtractor (a - b - bi) with valid/ready flow control on both sides.
module sub_8_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = sub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             of,
  output logic             out_valid,
  input  logic             out_ready
);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  s1_t  s1_q;
  s1_t  s1_d;

  logic [NIB-1:0] lo_s;
  logic           lo_cout;
  logic           unused_lo_c3;
  logic [NIB-1:0] hi_s;
  logic           hi_cout;
  logic           hi_c3;

  // Subtraction as a + ~b with carry-in ~bi; the high nibble is deferred to stage 2
  sub_cla_4 u_cla_lo (
    .x    (a[NIB-1:0]),
    .y    (~b[NIB-1:0]),
    .cin  (~bi),
    .s    (lo_s),
    .cout (lo_cout),
    .c3   (unused_lo_c3)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.d_lo  = lo_s;
    s1_d.c3    = lo_cout;
    s1_d.a_hi  = a[WIDTH-1:NIB];
    s1_d.nb_hi = ~b[WIDTH-1:NIB];
  end

  sub_cla_4 u_cla_hi (
    .x    (s1_q.a_hi),
    .y    (s1_q.nb_hi),
    .cin  (s1_q.c3),
    .s    (hi_s),
    .cout (hi_cout),
    .c3   (hi_c3)
  );

  // Backpressure chain is built only from stage state and out_ready, never from in_valid
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Borrow-out is the inverted final carry; overflow compares carries into and out of the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      d        <= '0;
      bo       <= 1'b0;
      of       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d  <= {hi_s, s1_q.d_lo};
        bo <= ~hi_cout;
        of <= hi_c3 ^ hi_cout;
      end
    end
  end

endmodule

// File: tb/tb_sub_8_pipe.sv
// Self-checking bench for sub_8_pipe: directed corner cases plus randomized traffic against a scoreboard.
module tb_sub_8_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       bi;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       bo;
  logic       of;
  logic       out_valid;
  logic       out_ready;

  int compare_count;
  int mismatch_count;

  logic [9:0] exp_q[$];
  logic       hold_pending;
  logic [9:0] held_result;

  sub_8_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .bo        (bo),
    .of        (of),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic logic [9:0] refModel(input logic [7:0] ra, input logic [7:0] rb, input logic rbi);
    int         udiff;
    int         sdiff;
    logic [7:0] rd;
    logic       rbo;
    logic       rof;
    udiff = int'(ra) - int'(rb) - int'(rbi);
    sdiff = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
    rd    = 8'(udiff);
    rbo   = (udiff < 0);
    rof   = (sdiff < -128) || (sdiff > 127);
    return {rd, rbo, rof};
  endfunction

  // Scoreboard: beats accepted at the coming edge are pushed, delivered results are popped
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'({d, bo, of}), 32'(held_result));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("result", 32'({d, bo, of}), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(refModel(a, b, bi));
      end
      hold_pending = out_valid && !out_ready;
      held_result  = {d, bo, of};
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                               input logic tbi, input logic ordy, output logic accepted);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = ta;
    b         = tb;
    bi        = tbi;
    out_ready = ordy;
    @(negedge clk);
    accepted = v && in_ready;
  endtask

  // Sends one beat with out_ready high and checks latency plus the exact result
  task automatic sendOne(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                         input logic [7:0] ed, input logic ebo, input logic eof);
    logic acc;
    int   wait_cycles;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      applyStimulus(1'b1, ta, tb, tbi, 1'b1, acc);
    end
    if (!acc) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    wait_cycles = 0;
    do begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
      wait_cycles++;
    end while (!out_valid && wait_cycles < 10);
    checkOutput("latency", 32'(wait_cycles), 32'd2);
    checkOutput("direct_d", 32'(d), 32'(ed));
    checkOutput("direct_bo", 32'(bo), 32'(ebo));
    checkOutput("direct_of", 32'(of), 32'(eof));
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
      n++;
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic       acc;
    int         idx;
    int         sent;
    int         cycles;
    logic [7:0] bb_a[4];
    logic [7:0] bb_b[4];

    compare_count  = 0;
    mismatch_count = 0;
    hold_pending   = 1'b0;
    held_result    = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    bi        = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_d", 32'({d, bo, of}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed corner cases");
    sendOne(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    sendOne(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    sendOne(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    sendOne(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    sendOne(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    $display("[TB] back-to-back with output stalled");
    bb_a = '{8'h11, 8'h42, 8'h90, 8'hFE};
    bb_b = '{8'h01, 8'h50, 8'h10, 8'h7F};
    idx  = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, bb_a[idx], bb_b[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("stall_accepted", 32'(idx), 32'd2);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    cycles = 0;
    while (idx < 4 && cycles < 20) begin
      applyStimulus(1'b1, bb_a[idx], bb_b[idx], 1'b0, 1'b1, acc);
      if (acc) idx++;
      cycles++;
    end
    checkOutput("stall_all_sent", 32'(idx), 32'd4);
    drain();

    $display("[TB] reset with beats in flight");
    idx = 0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 8'(8'h20 + c), 8'h03, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("inflight_count", 32'(idx), 32'd2);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
      checkOutput("post_reset_stale", 32'(out_valid), 32'd0);
    end
    sendOne(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    sent   = 0;
    cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      cycles++;
    end
    checkOutput("random_sent", 32'(sent), 32'd1000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
